// File: rtl/ps2_kbd_cmd_ctrl.sv
// PS/2 keyboard command sequencer: reset/BAT bring-up, LED updates with ACK/resend/retry
// handling, and forwarding of unsolicited device bytes to the scan-code decoder.
module ps2_kbd_cmd_ctrl #(
  parameter int TIMEOUT_BITS = 25,
  parameter int MAX_RETRY    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       led_req,
  input  logic [2:0] led_mask,
  output logic       led_busy,
  output logic       init_done,
  output logic       err,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       ps2_wr_stb,
  output logic [7:0] ps2_wr_data,
  input  logic       ps2_tx_ready,
  input  logic       ps2_tx_done,
  input  logic       ps2_rddata_valid,
  input  logic [7:0] ps2_rd_data
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;
  localparam logic [7:0] RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    PH_INIT_RST,
    PH_INIT_BAT,
    PH_READY,
    PH_LED_CMD,
    PH_LED_ARG,
    PH_FAIL
  } phase_t;

  // Sub-state of the byte exchange used by every command-sending phase.
  typedef enum logic [1:0] {
    XF_SEND,
    XF_TXD,
    XF_ACK
  } xfer_t;

  phase_t                  phase_q, phase_d;
  xfer_t                   xfer_q, xfer_d;
  logic [TIMEOUT_BITS-1:0] timer_q, timer_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic                    pending_q, pending_d;
  logic [2:0]              pend_mask_q, pend_mask_d;
  logic [2:0]              cur_mask_q, cur_mask_d;

  logic       ack_evt, retry_evt, bat_ok, leave_ready, in_exchange;
  logic       wr_stb_d, key_valid_d, init_done_d, err_d, led_busy_d;
  logic [7:0] wr_data_d, key_code_d;

  assign in_exchange = (phase_q == PH_INIT_RST) || (phase_q == PH_LED_CMD) ||
                       (phase_q == PH_LED_ARG);

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= PH_INIT_RST;
      xfer_q      <= XF_SEND;
      timer_q     <= '1;
      retry_q     <= '0;
      pending_q   <= 1'b0;
      pend_mask_q <= 3'b000;
      cur_mask_q  <= 3'b000;
      ps2_wr_stb  <= 1'b0;
      ps2_wr_data <= CMD_RESET;
      key_valid   <= 1'b0;
      key_code    <= 8'h00;
      init_done   <= 1'b0;
      err         <= 1'b0;
      led_busy    <= 1'b1;
    end else begin
      phase_q     <= phase_d;
      xfer_q      <= xfer_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pending_q   <= pending_d;
      pend_mask_q <= pend_mask_d;
      cur_mask_q  <= cur_mask_d;
      ps2_wr_stb  <= wr_stb_d;
      ps2_wr_data <= wr_data_d;
      key_valid   <= key_valid_d;
      key_code    <= key_code_d;
      init_done   <= init_done_d;
      err         <= err_d;
      led_busy    <= led_busy_d;
    end
  end

  // The timer saturates at zero so a discarded byte on the expiry cycle defers the timeout by one cycle.
  always_comb begin
    phase_d     = phase_q;
    xfer_d      = xfer_q;
    timer_d     = (timer_q == '0) ? '0 : timer_q - TIMEOUT_BITS'(1);
    retry_d     = retry_q;
    cur_mask_d  = cur_mask_q;
    ack_evt     = 1'b0;
    retry_evt   = 1'b0;
    bat_ok      = 1'b0;
    leave_ready = 1'b0;

    case (phase_q)
      PH_INIT_RST, PH_LED_CMD, PH_LED_ARG: begin
        case (xfer_q)
          XF_SEND: begin
            if (ps2_tx_ready) begin
              xfer_d  = XF_TXD;
              timer_d = '1;
            end
          end
          XF_TXD: begin
            if (ps2_tx_done) begin
              xfer_d  = XF_ACK;
              timer_d = '1;
            end else if (timer_q == '0) begin
              retry_evt = 1'b1;
            end
          end
          XF_ACK: begin
            if (ps2_rddata_valid) begin
              if (ps2_rd_data == RSP_ACK) begin
                ack_evt = 1'b1;
              end else if (ps2_rd_data == RSP_RESEND) begin
                retry_evt = 1'b1;
              end
            end else if (timer_q == '0) begin
              retry_evt = 1'b1;
            end
          end
          default: xfer_d = XF_SEND;
        endcase
      end
      PH_INIT_BAT: begin
        if (ps2_rddata_valid) begin
          if (ps2_rd_data == RSP_BAT_OK) begin
            bat_ok = 1'b1;
          end else if (ps2_rd_data == RSP_BAT_FAIL) begin
            retry_evt = 1'b1;
          end
        end else if (timer_q == '0) begin
          retry_evt = 1'b1;
        end
      end
      PH_READY: begin
        if (pending_q) begin
          leave_ready = 1'b1;
          phase_d     = PH_LED_CMD;
          xfer_d      = XF_SEND;
          cur_mask_d  = pend_mask_q;
        end
      end
      PH_FAIL: phase_d = PH_FAIL;
      default: phase_d = PH_INIT_RST;
    endcase

    if (ack_evt) begin
      retry_d = '0;
      xfer_d  = XF_SEND;
      case (phase_q)
        PH_INIT_RST: begin
          phase_d = PH_INIT_BAT;
          timer_d = '1;
        end
        PH_LED_CMD: phase_d = PH_LED_ARG;
        default:    phase_d = PH_READY;
      endcase
    end

    if (bat_ok) begin
      retry_d = '0;
      phase_d = PH_READY;
    end

    // A failed BAT repeats the whole reset exchange; LED_ARG retries resend only the argument.
    if (retry_evt) begin
      if (retry_q == RETRY_LIMIT) begin
        phase_d = PH_FAIL;
      end else begin
        retry_d = retry_q + RW'(1);
        xfer_d  = XF_SEND;
        if (phase_q == PH_INIT_BAT) begin
          phase_d = PH_INIT_RST;
        end
      end
    end

    pending_d   = led_req | (pending_q & ~leave_ready);
    pend_mask_d = led_req ? led_mask : pend_mask_q;
  end

  always_comb begin
    wr_stb_d  = in_exchange && (xfer_q == XF_SEND) && ps2_tx_ready;
    wr_data_d = ps2_wr_data;
    case (phase_d)
      PH_INIT_RST: wr_data_d = CMD_RESET;
      PH_LED_CMD:  wr_data_d = CMD_SET_LED;
      PH_LED_ARG:  wr_data_d = {5'b00000, cur_mask_d};
      default:     wr_data_d = ps2_wr_data;
    endcase
    key_valid_d = (phase_q == PH_READY) && ps2_rddata_valid;
    key_code_d  = key_valid_d ? ps2_rd_data : key_code;
    init_done_d = init_done | bat_ok;
    err_d       = err | (phase_d == PH_FAIL);
    led_busy_d  = !((phase_d == PH_READY) && !pending_d);
  end

endmodule

// File: tb/tb_ps2_kbd_cmd_ctrl.sv
// Scoreboard bench for ps2_kbd_cmd_ctrl: the bench plays keyboard and transceiver, queues the
// byte stream the command rules predict, and a monitor compares every strobe and forwarded key.
module tb_ps2_kbd_cmd_ctrl;

  localparam int TB_TIMEOUT_BITS = 6;
  localparam int TB_MAX_RETRY    = 3;
  localparam int WAIT_LIMIT      = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       led_req = 1'b0;
  logic [2:0] led_mask = 3'b000;
  logic       led_busy, init_done, err, key_valid;
  logic [7:0] key_code;
  logic       ps2_wr_stb;
  logic [7:0] ps2_wr_data;
  logic       ps2_tx_ready = 1'b1;
  logic       ps2_tx_done = 1'b0;
  logic       ps2_rddata_valid = 1'b0;
  logic [7:0] ps2_rd_data = 8'h00;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int stb_count = 0;
  int stb_handled = 0;

  typedef struct {
    logic [7:0] code;
    int         at;
  } key_exp_t;

  logic [7:0] exp_tx[$];
  key_exp_t   exp_key[$];

  ps2_kbd_cmd_ctrl #(
    .TIMEOUT_BITS(TB_TIMEOUT_BITS),
    .MAX_RETRY   (TB_MAX_RETRY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .led_req         (led_req),
    .led_mask        (led_mask),
    .led_busy        (led_busy),
    .init_done       (init_done),
    .err             (err),
    .key_valid       (key_valid),
    .key_code        (key_code),
    .ps2_wr_stb      (ps2_wr_stb),
    .ps2_wr_data     (ps2_wr_data),
    .ps2_tx_ready    (ps2_tx_ready),
    .ps2_tx_done     (ps2_tx_done),
    .ps2_rddata_valid(ps2_rddata_valid),
    .ps2_rd_data     (ps2_rd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportMissing(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %s, expected nothing", name, what);
  endtask

  // Monitor: every strobe and every forwarded key is matched against the scoreboard queues.
  always @(negedge clk) begin
    key_exp_t e;
    logic [7:0] b;
    if (ps2_wr_stb === 1'b1) begin
      stb_count <= stb_count + 1;
      if (exp_tx.size() == 0) begin
        reportMissing("unexpected_tx", $sformatf("strobe with 0x%0h", ps2_wr_data));
      end else begin
        b = exp_tx.pop_front();
        checkOutput("tx_byte", {24'h0, ps2_wr_data}, {24'h0, b});
      end
    end
    if (key_valid === 1'b1) begin
      if (exp_key.size() == 0) begin
        reportMissing("unexpected_key", $sformatf("key 0x%0h", key_code));
      end else begin
        e = exp_key.pop_front();
        checkOutput("key_code", {24'h0, key_code}, {24'h0, e.code});
        checkOutput("key_latency", cycle, e.at);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [2:0] mask);
    led_mask = mask;
    led_req  = 1'b1;
    tick(1);
    led_req  = 1'b0;
  endtask

  task automatic pulseByte(input logic [7:0] b, input bit fwd);
    key_exp_t e;
    ps2_rd_data      = b;
    ps2_rddata_valid = 1'b1;
    if (fwd) begin
      e.code = b;
      e.at   = cycle + 1;
      exp_key.push_back(e);
    end
    tick(1);
    ps2_rddata_valid = 1'b0;
  endtask

  task automatic waitStrobe();
    int n = 0;
    while (stb_count == stb_handled && n < WAIT_LIMIT) begin
      tick(1);
      n++;
    end
    if (stb_count == stb_handled) begin
      reportMissing("strobe_wait", "timeout waiting for a strobe,");
    end else begin
      stb_handled++;
    end
  endtask

  // mode 0: tx_done then reply resp; mode 1: tx_done, no reply; mode 2: no tx_done.
  task automatic exchange(input logic [7:0] resp, input int mode, input bit noise);
    waitStrobe();
    ps2_tx_ready = 1'b0;
    tick($urandom_range(1, 4));
    if (mode != 2) begin
      ps2_tx_done = 1'b1;
      tick(1);
      ps2_tx_done = 1'b0;
    end
    ps2_tx_ready = 1'b1;
    if (mode == 0) begin
      tick($urandom_range(0, 5));
      if (noise) begin
        pulseByte(8'h1C, 1'b0);
        tick(1);
      end
      pulseByte(resp, 1'b0);
    end
  endtask

  task automatic failedExchange();
    case ($urandom_range(0, 2))
      0:       exchange(8'hFE, 0, 1'b0);
      1:       exchange(8'h00, 1, 1'b0);
      default: exchange(8'h00, 2, 1'b0);
    endcase
  endtask

  // Reference: an LED update sends 0xED once per attempt, then the mask byte once per attempt.
  task automatic ledUpdate(input logic [2:0] mask, input int nc, input int na);
    for (int i = 0; i <= nc; i++) exp_tx.push_back(8'hED);
    for (int i = 0; i <= na; i++) exp_tx.push_back({5'b00000, mask});
    for (int i = 0; i < nc; i++) failedExchange();
    exchange(8'hFA, 0, 1'b0);
    for (int i = 0; i < na; i++) failedExchange();
    exchange(8'hFA, 0, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [2:0] m;
    int nc, na, base;

    rst = 1'b1;
    tick(4);
    checkOutput("rst_wr_stb", {31'h0, ps2_wr_stb}, 32'h0);
    checkOutput("rst_wr_data", {24'h0, ps2_wr_data}, 32'hFF);
    checkOutput("rst_key_valid", {31'h0, key_valid}, 32'h0);
    checkOutput("rst_key_code", {24'h0, key_code}, 32'h0);
    checkOutput("rst_init_done", {31'h0, init_done}, 32'h0);
    checkOutput("rst_err", {31'h0, err}, 32'h0);
    checkOutput("rst_led_busy", {31'h0, led_busy}, 32'h1);

    // Normal init with a junk byte during the BAT wait.
    exp_tx.push_back(8'hFF);
    rst = 1'b0;
    exchange(8'hFA, 0, 1'b0);
    tick(3);
    pulseByte(8'h55, 1'b0);
    tick(2);
    checkOutput("init_done_pre_bat", {31'h0, init_done}, 32'h0);
    pulseByte(8'hAA, 1'b0);
    tick(2);
    checkOutput("init_done", {31'h0, init_done}, 32'h1);
    checkOutput("idle_led_busy", {31'h0, led_busy}, 32'h0);
    checkOutput("init_err", {31'h0, err}, 32'h0);
    checkOutput("init_strobes", stb_count, 1);

    // Forwarding: back-to-back directed bytes, then random bytes with random gaps.
    pulseByte(8'h1C, 1'b1);
    pulseByte(8'hF0, 1'b1);
    pulseByte(8'h1C, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick($urandom_range(0, 3));
      pulseByte(8'($urandom_range(0, 255)), 1'b1);
    end
    tick(2);

    // Directed LED update with a stray byte during the 0xED ACK wait.
    applyStimulus(3'b101);
    checkOutput("led_busy_on_req", {31'h0, led_busy}, 32'h1);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h05);
    exchange(8'hFA, 0, 1'b1);
    exchange(8'hFA, 0, 1'b0);
    tick(2);
    checkOutput("led_busy_after_update", {31'h0, led_busy}, 32'h0);

    // Resend of the argument byte only.
    applyStimulus(3'b101);
    ledUpdate(3'b101, 0, 0);
    tick(2);
    applyStimulus(3'b101);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h05);
    exp_tx.push_back(8'h05);
    exchange(8'hFA, 0, 1'b0);
    exchange(8'hFE, 0, 1'b0);
    exchange(8'hFA, 0, 1'b0);
    tick(2);
    checkOutput("resend_err", {31'h0, err}, 32'h0);
    checkOutput("resend_led_busy", {31'h0, led_busy}, 32'h0);

    // Random LED updates with bounded retries and optional simultaneous key byte.
    for (int it = 0; it < 8; it++) begin
      m  = 3'($urandom_range(0, 7));
      nc = $urandom_range(0, TB_MAX_RETRY);
      na = $urandom_range(0, TB_MAX_RETRY);
      applyStimulus(m);
      if ($urandom_range(0, 1) == 1) pulseByte(8'($urandom_range(0, 255)), 1'b1);
      ledUpdate(m, nc, na);
      tick(2);
      checkOutput("rand_led_busy", {31'h0, led_busy}, 32'h0);
      checkOutput("rand_err", {31'h0, err}, 32'h0);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) pulseByte(8'($urandom_range(0, 255)), 1'b1);
      tick($urandom_range(1, 4));
    end

    // Request arriving during an update is serviced afterwards with its own mask.
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h03);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h06);
    applyStimulus(3'b011);
    exchange(8'hFA, 0, 1'b0);
    applyStimulus(3'b110);
    exchange(8'hFA, 0, 1'b0);
    checkOutput("busy_with_queued", {31'h0, led_busy}, 32'h1);
    exchange(8'hFA, 0, 1'b0);
    exchange(8'hFA, 0, 1'b0);
    tick(2);
    checkOutput("queued_led_busy", {31'h0, led_busy}, 32'h0);

    // Silent keyboard: four reset attempts, then FAIL with no further activity.
    rst = 1'b1;
    tick(2);
    stb_handled = stb_count;
    base = stb_count;
    for (int i = 0; i <= TB_MAX_RETRY; i++) exp_tx.push_back(8'hFF);
    rst = 1'b0;
    for (int i = 0; i <= TB_MAX_RETRY; i++) exchange(8'h00, 1, 1'b0);
    tick(150);
    pulseByte(8'h1C, 1'b0);
    applyStimulus(3'b111);
    tick(200);
    checkOutput("fail_err", {31'h0, err}, 32'h1);
    checkOutput("fail_init_done", {31'h0, init_done}, 32'h0);
    checkOutput("fail_led_busy", {31'h0, led_busy}, 32'h1);
    checkOutput("fail_strobes", stb_count - base, TB_MAX_RETRY + 1);

    // Reset recovers; two requests during init collapse into one update with the last mask.
    rst = 1'b1;
    tick(2);
    checkOutput("rerst_err", {31'h0, err}, 32'h0);
    stb_handled = stb_count;
    exp_tx.push_back(8'hFF);
    rst = 1'b0;
    applyStimulus(3'b001);
    exchange(8'hFA, 0, 1'b0);
    applyStimulus(3'b010);
    exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h02);
    tick(2);
    pulseByte(8'hAA, 1'b0);
    exchange(8'hFA, 0, 1'b0);
    exchange(8'hFA, 0, 1'b0);
    tick(2);
    checkOutput("requeue_init_done", {31'h0, init_done}, 32'h1);
    checkOutput("requeue_led_busy", {31'h0, led_busy}, 32'h0);
    checkOutput("requeue_err", {31'h0, err}, 32'h0);

    tick(50);
    checkOutput("tx_queue_left", exp_tx.size(), 0);
    checkOutput("key_queue_left", exp_key.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
